// File: rtl/rr_arb8_pkg.sv
// Shared types, widths and the round-robin search helper for the 8-way arbiter.
package rr_arb8_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // First set request at or above ptr, wrapping 7->0; returns ptr when req is empty.
   function automatic logic [IDX_W-1:0] next_rr(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] win;
      logic [IDX_W-1:0] idx;
      logic             found;
      win   = ptr;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ptr + IDX_W'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/arb_onehot_dec.sv
// 3-to-8 enable decoder: one-hot output of s when e is high, all zero otherwise.
module arb_onehot_dec
   import rr_arb8_pkg::*;
(
   input  logic             e,
   input  logic [IDX_W-1:0] s,
   output logic [N_REQ-1:0] y_c
);

   always_comb begin
      y_c = '0;
      if (e) y_c[s] = 1'b1;
   end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// 8-requester round-robin arbiter with request/release handshake and optional
// maximum hold time; gnt is the one-hot decode of the registered winner.
module rr_arb8_ctrl
   import rr_arb8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned HC_W     = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             busy
);

   localparam logic            HOLD_LIM  = (MAX_HOLD != 0);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0] gnt_idx_d;
   logic             gnt_valid_d;
   logic             release_c;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         gnt_idx    <= '0;
         gnt_valid  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_idx    <= gnt_idx_d;
         gnt_valid  <= gnt_valid_d;
         busy       <= gnt_valid_d;
      end
   end

   // Next-state: arbitrate in IDLE, hold/release in GRANT
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      gnt_idx_d   = gnt_idx;
      gnt_valid_d = gnt_valid;
      release_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (en && (req != '0)) begin
               gnt_idx_d   = next_rr(req, ptr_q);
               gnt_valid_d = 1'b1;
               hold_cnt_d  = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            release_c = !req[gnt_idx] || !en || (HOLD_LIM && (hold_cnt_q == HOLD_LAST));
            if (release_c) begin
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_idx + IDX_W'(1);
               state_d     = IDLE;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + HC_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   arb_onehot_dec u_dec (
      .e   (gnt_valid),
      .s   (gnt_idx),
      .y_c (gnt)
   );

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Directed bench for rr_arb8_ctrl: three instances (MAX_HOLD 16, 2, 0) share inputs.
module tb_rr_arb8_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] req;

   logic [7:0] gnt_d, gnt_r, gnt_u;
   logic [2:0] idx_d, idx_r, idx_u;
   logic       vld_d, vld_r, vld_u;
   logic       busy_d, busy_r, busy_u;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rr_arb8_ctrl #(.MAX_HOLD(16), .HC_W(5)) dut_d (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt_d), .gnt_idx(idx_d), .gnt_valid(vld_d), .busy(busy_d));

   rr_arb8_ctrl #(.MAX_HOLD(2), .HC_W(5)) dut_r (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt_r), .gnt_idx(idx_r), .gnt_valid(vld_r), .busy(busy_r));

   rr_arb8_ctrl #(.MAX_HOLD(0), .HC_W(5)) dut_u (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt_u), .gnt_idx(idx_u), .gnt_valid(vld_u), .busy(busy_u));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      en    = 1'b0;
      req   = 8'h00;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // sel: 0 = MAX_HOLD 16, 1 = MAX_HOLD 2, 2 = unlimited
   task automatic chk(input string tag, input int sel, input logic [7:0] exp_g);
      logic [7:0] g;
      logic [2:0] i;
      logic [2:0] ei;
      logic       v;
      logic       b;
      case (sel)
         0:       begin g = gnt_d; i = idx_d; v = vld_d; b = busy_d; end
         1:       begin g = gnt_r; i = idx_r; v = vld_r; b = busy_r; end
         default: begin g = gnt_u; i = idx_u; v = vld_u; b = busy_u; end
      endcase
      ei = 3'd0;
      for (int k = 0; k < 8; k++) if (exp_g[k]) ei = 3'(k);
      n_cmp++;
      assert ({g, v, b} === {exp_g, |exp_g, |exp_g}) else begin
         n_err++;
         $error("FAIL %s: gnt/valid/busy got %h/%b/%b expected %h/%b/%b",
                tag, g, v, b, exp_g, |exp_g, |exp_g);
      end
      if (exp_g != 8'h00) begin
         n_cmp++;
         assert (i === ei) else begin
            n_err++;
            $error("FAIL %s_idx: gnt_idx got %0d expected %0d", tag, i, ei);
         end
      end
   endtask

   initial begin
      rst_n = 1'b1;
      en    = 1'b0;
      req   = 8'h00;
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk("reset_state", 0, 8'h00);
      n_cmp++;
      assert (idx_d === 3'd0) else begin
         n_err++;
         $error("FAIL reset_idx: gnt_idx got %0d expected 0", idx_d);
      end

      // Async reset mid-grant
      rst_n = 1'b1;
      en    = 1'b1;
      req   = 8'hFF;
      tick();
      chk("pre_reset_grant", 0, 8'h01);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_drop", 0, 8'h00);
      req   = 8'h01;
      rst_n = 1'b1;
      tick();
      chk("post_reset_grant", 0, 8'h01);

      // Handshake release and wrap search from ptr=4
      do_reset();
      en  = 1'b1;
      req = 8'h08;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk("hs_hold", 0, 8'h08);
      end
      req = 8'h00;
      tick();
      chk("hs_release", 0, 8'h00);
      req = 8'h09;
      tick();
      chk("hs_wrap_idx0", 0, 8'h01);

      // Wrap priority: idx 6 then 7 then 0
      do_reset();
      en  = 1'b1;
      req = 8'h40;
      tick();
      chk("wrap_idx6", 0, 8'h40);
      req = 8'h00;
      tick();
      chk("wrap_rel6", 0, 8'h00);
      req = 8'h81;
      tick();
      chk("wrap_idx7", 0, 8'h80);
      req = 8'h01;
      tick();
      chk("wrap_rel7", 0, 8'h00);
      tick();
      chk("wrap_idx0", 0, 8'h01);

      // Enable gating
      do_reset();
      en  = 1'b0;
      req = 8'h10;
      tick();
      chk("en_low_a", 0, 8'h00);
      tick();
      chk("en_low_b", 0, 8'h00);
      en = 1'b1;
      tick();
      chk("en_rise_grant", 0, 8'h10);
      tick();
      chk("en_hold", 0, 8'h10);
      en = 1'b0;
      tick();
      chk("en_drop_release", 0, 8'h00);
      tick();
      chk("en_drop_stay", 0, 8'h00);

      // Forced release at MAX_HOLD=16 with sole requester
      do_reset();
      en  = 1'b1;
      req = 8'h20;
      for (int c = 1; c <= 16; c++) begin
         tick();
         chk("max16_hold", 0, 8'h20);
      end
      tick();
      chk("max16_dead", 0, 8'h00);
      tick();
      chk("max16_regrant", 0, 8'h20);

      // Rotation with MAX_HOLD=2
      do_reset();
      en  = 1'b1;
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         logic [7:0] oh;
         oh = 8'h01 << (k % 8);
         tick();
         chk("rot_first", 1, oh);
         tick();
         chk("rot_second", 1, oh);
         tick();
         chk("rot_dead", 1, 8'h00);
      end

      // Unlimited hold
      do_reset();
      en  = 1'b1;
      req = 8'h03;
      for (int c = 0; c < 100; c++) begin
         tick();
         chk("unl_hold", 2, 8'h01);
      end
      req = 8'h02;
      tick();
      chk("unl_release", 2, 8'h00);
      tick();
      chk("unl_next", 2, 8'h02);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rr_arb8_ctrl.md
Name: rr_arb8_ctrl

Overview:
- 8-requester round-robin arbiter that owns one shared resource slot.
- Selects one winner index, holds it under a request/release handshake, and enforces an optional maximum hold time.
- Drives a 3-to-8 enable decoder to produce a one-hot grant vector.
- Sits between eight requesting engines and the shared resource select lines.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per winner; 0 = unlimited.
- HC_W, 5: hold counter width; must satisfy 2^HC_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbiter enable; low forces release and blocks new grants.
- req  input  8  request lines, one per requester, level-sensitive.
- gnt  output  8  one-hot grant; all zero when no grant.
- gnt_idx  output  3  binary index of current winner.
- gnt_valid  output  1  high while a grant is held.
- busy  output  1  equals gnt_valid (resource occupied).

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Reset clears state to IDLE, ptr=0, hold_cnt=0, gnt_idx=0, gnt_valid=0, gnt=8'h00, busy=0. Reset mid-grant drops the grant immediately, without waiting for a clock edge.
- All outputs are registered, except gnt, which is the combinational decode of {gnt_valid, gnt_idx}.
- The state machine has two states, IDLE and GRANT. ptr[2:0] holds the highest-priority index.
- IDLE, at an edge with en=1 and req!=0:
  - Winner = first set bit of req searched from ptr upward, wrapping 7->0.
  - Register gnt_idx=winner, gnt_valid=1, hold_cnt=0; go to GRANT.
  - Latency: req sampled at edge k -> gnt visible after edge k (1 cycle).
- IDLE with en=0 or req==0: stay in IDLE; outputs stay cleared.
- GRANT: hold_cnt increments each edge, saturating.
- GRANT releases at an edge when any of these is true:
  - (a) req[gnt_idx]==0;
  - (b) en==0;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- On release:
  - gnt_valid=0; gnt_idx is retained (don't-care).
  - ptr=gnt_idx+1, with 7 wrapping to 0.
  - Go to IDLE.
  - Exactly one dead cycle follows before the next grant; the earliest new grant is at the following edge.
- Maximum grant duration is MAX_HOLD cycles. If the forced-release requester keeps req high, it is re-eligible at its new round-robin position, behind the other requesters.
- Requests on other lines during GRANT are ignored until release and do not preempt.
- Simultaneous release and a new request: the release takes priority. Arbitration happens in the next IDLE cycle using the updated ptr.
- Width rules:
  - ptr and gnt_idx are 3-bit modulo-8.
  - The search is a fixed 8-way rotate plus priority encode; the result is unique.
- Invariant: gnt is one-hot or zero. gnt[gnt_idx]=gnt_valid.

Decomposition:
- Package rr_arb8_pkg holds:
  - N_REQ=8 and IDX_W=3;
  - typedef arb_state_t {IDLE, GRANT};
  - function next_rr(req, ptr) returning the winner index.
- Sub-module arb_onehot_dec is a 3-to-8 enable decoder (E=gnt_valid, S=gnt_idx, Y=gnt), instantiated once.

Test Plan:
- Reset: assert rst_n=0 mid-grant with req=8'hFF -> gnt=8'h00, gnt_valid=0 immediately; after release with req=8'h01, first grant is gnt=8'h01 one cycle later.
- Rotation: req=8'hFF held, MAX_HOLD=2 -> grants cycle idx 0,1,2,...,7,0. Each grant is 2 cycles, followed by 1 idle cycle.
- Handshake release: grant idx 3 (req=8'h08); drop req[3] at cycle 5 -> gnt_valid=0 next edge, ptr=4. Then req=8'h09 -> grant idx 0 (search 4..7 empty, wrap).
- Wrap priority: ptr=7 via prior grant of idx 6; req=8'h81 -> grant idx 7, then idx 0.
- Enable: en=0 with req=8'h10 -> no grant. Raise en -> gnt=8'h10 after 1 edge. Drop en during grant -> release next edge.
- Unlimited hold: MAX_HOLD=0, req=8'h03 held 100 cycles -> idx 0 held all 100 cycles with no rotation. Drop req[0] -> idx 1 granted after the dead cycle.
